// File: rtl/ws2812b_rx_pkg.sv
// Shared WS2812B line constants and receiver state encoding.
// Latency: n/a (package). Backpressure: n/a.
// Contents: transmitter bit timings (cycles at 20 MHz), word width, receiver FSM states.
package ws2812b_pkg;

  // Bit timings used by the transmitter; high/low cycle counts at 20 MHz.
  localparam int T0H     = 8;
  localparam int T1H     = 16;
  localparam int T0L     = 17;
  localparam int T1L     = 9;
  localparam int T_LATCH = 1000;

  localparam int WORD_W  = 24;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ws2812b_rx_if.sv
// Decoded-word stream plus status pulses leaving the WS2812B receiver.
// Latency: n/a (wiring). Backpressure: valid/ready on data_out.
// Ports: data_out/valid/ready word stream; latch/error/overrun one-cycle pulses.
interface ws2812b_rx_if;
  import ws2812b_pkg::*;

  logic [WORD_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              latch;
  logic              error;
  logic              overrun;

  modport master (output data_out, valid, latch, error, overrun, input ready);
  modport slave  (input data_out, valid, latch, error, overrun, output ready);
endinterface

// File: rtl/ws2812b_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges. Backpressure: none.
// Ports: clk, reset (async active-high), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B serial decoder: 24-bit GRB words MSB first, latch-gap and framing-error detection.
// Latency: valid rises on the 3rd clk edge after din falls for the 24th bit.
// Backpressure: data_out held while valid & !ready; a word completing then is dropped (overrun).
// Ports: clk, reset (async active-high), din (async serial in), rx (master stream + status pulses).
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int CLOCK_RATE   = 20000000,
  parameter int T_MIN_HIGH   = 3,
  parameter int T_BIT_THRESH = 12,
  parameter int T_MAX_HIGH   = 40,
  parameter int T_LATCH      = ws2812b_pkg::T_LATCH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din,
  ws2812b_rx_if.master rx
);

  if (CLOCK_RATE < 1 || T_MIN_HIGH < 1 || T_BIT_THRESH <= T_MIN_HIGH ||
      T_MAX_HIGH <= T_BIT_THRESH || T_LATCH <= T_MAX_HIGH) begin : g_bad_params
    $error("ws2812b_rx: inconsistent timing parameters");
  end

  localparam int CW = $clog2(T_LATCH + 1);
  // "reaches N" is tested on the cycle whose increment would make the count N.
  localparam logic [CW-1:0] LATCH_LAST = CW'(T_LATCH - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(T_MAX_HIGH - 1);
  localparam logic [CW-1:0] MIN_HIGH   = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] BIT_THRESH = CW'(T_BIT_THRESH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [4:0]    LAST_BIT   = 5'(WORD_W - 1);

  logic              din_s;
  rx_state_e         state;
  logic [CW-1:0]     cnt;        // shared by SYNC gap, high time and low time
  logic [WORD_W-2:0] shift;      // first 23 bits; the 24th goes straight to data_out
  logic [4:0]        bit_cnt;
  logic [WORD_W-1:0] data_q;
  logic              valid_q, latch_q, error_q, overrun_q;
  logic              bit_val;

  sync_2ff u_sync (.clk(clk), .reset(reset), .d(din), .q(din_s));

  assign bit_val = (cnt >= BIT_THRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      cnt       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      latch_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      if (valid_q && rx.ready) valid_q <= 1'b0;

      case (state)
        // Wait for a full latch gap before trusting bit boundaries.
        SYNC: begin
          if (din_s) begin
            cnt <= '0;
          end else if (cnt == LATCH_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        IDLE: begin
          if (din_s) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end
        end

        HIGH: begin
          if (din_s) begin
            if (cnt == MAX_LAST) begin
              error_q <= 1'b1;
              cnt     <= '0;
              bit_cnt <= '0;
              state   <= SYNC;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else if (cnt < MIN_HIGH) begin
            error_q <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SYNC;
          end else begin
            cnt   <= CNT_ONE;
            state <= LOW;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              // An acceptance on this same edge frees the slot for the new word.
              if (!valid_q || rx.ready) begin
                data_q  <= {shift, bit_val};
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              shift   <= {shift[WORD_W-3:0], bit_val};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        LOW: begin
          if (din_s) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end else if (cnt == LATCH_LAST) begin
            latch_q <= 1'b1;
            error_q <= (bit_cnt != 5'd0);
            bit_cnt <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

  assign rx.data_out = data_q;
  assign rx.valid    = valid_q;
  assign rx.latch    = latch_q;
  assign rx.error    = error_q;
  assign rx.overrun  = overrun_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic din;
  ws2812b_rx_if rx ();

  ws2812b_rx dut (.clk(clk), .reset(reset), .din(din), .rx(rx));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counters sampled on the falling edge.
  int n_got = 0, n_latch = 0, n_err = 0, n_ovr = 0, n_valid = 0;
  int rise_cyc = 0, latch_cyc = 0, err_cyc = 0, fall_cyc = 0;
  logic [23:0] last_got = '0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx.valid) n_valid++;
      if (rx.valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx.valid;
      if (rx.valid && rx.ready) begin n_got++; last_got = rx.data_out; end
      if (rx.latch) begin n_latch++; latch_cyc = cyc; end
      if (rx.error) begin n_err++; err_cyc = cyc; end
      if (rx.overrun) n_ovr++;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int h0, input int h1, input int l0, input int l1);
    din = 1'b1;
    repeat (b ? h1 : h0) @(posedge clk);
    #1 din = 1'b0;
    fall_cyc = cyc;
    repeat (b ? l1 : l0) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] w, input int n,
                           input int h0, input int h1, input int l0, input int l1);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i], h0, h1, l0, l1);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 24, T0H, T1H, T0L, T1L);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [23:0] word;
    int h0, h1, l0, l1;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[5];
  int g0, l0c, e0, o0, v0;

  initial begin
    // word, 0-high, 1-high, 0-low, 1-low, expected decode
    vecs[0] = '{24'hFF8001,  8, 16, 17,  9, 24'hFF8001};
    vecs[1] = '{24'h000000,  8, 16, 17,  9, 24'h000000};
    vecs[2] = '{24'hA5A55A, 11, 12, 17,  9, 24'hA5A55A};  // either side of bit threshold
    vecs[3] = '{24'h3C3C3C,  3, 39, 20, 20, 24'h3C3C3C};  // shortest legal / longest legal high
    vecs[4] = '{24'hFFFFFF, 16, 16,  9,  9, 24'hFFFFFF};  // every bit a 1

    reset = 1'b1; din = 1'b0; rx.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(rx.data_out), 32'h0);
    chk("rst_valid", 32'(rx.valid), 32'h0);
    chk("rst_latch", 32'(rx.latch), 32'h0);
    chk("rst_error", 32'(rx.error), 32'h0);
    chk("rst_overrun", 32'(rx.overrun), 32'h0);
    reset = 1'b0;
    gap(1005);

    // Table: decode with ready=1, then a latch gap after each word.
    rx.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g0 = n_got; l0c = n_latch; e0 = n_err; o0 = n_ovr; v0 = n_valid;
      send_bits(vecs[i].word, 24, vecs[i].h0, vecs[i].h1, vecs[i].l0, vecs[i].l1);
      chk($sformatf("v%0d_latency", i), 32'(rise_cyc - fall_cyc), 32'd3);
      gap(1000);
      chk($sformatf("v%0d_ngot", i), 32'(n_got - g0), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(last_got), 32'(vecs[i].exp));
      chk($sformatf("v%0d_valid_cycles", i), 32'(n_valid - v0), 32'd1);
      chk($sformatf("v%0d_latch", i), 32'(n_latch - l0c), 32'd1);
      chk($sformatf("v%0d_err_ovr", i), 32'((n_err - e0) + (n_ovr - o0)), 32'd0);
    end

    // Backpressure and overrun.
    rx.ready = 1'b0;
    g0 = n_got; l0c = n_latch; o0 = n_ovr;
    send_word(24'h123456);
    send_word(24'hABCDEF);
    chk("bp_valid_held", 32'(rx.valid), 32'h1);
    chk("bp_data_held", 32'(rx.data_out), 32'h123456);
    chk("bp_overrun", 32'(n_ovr - o0), 32'd1);
    chk("bp_no_accept", 32'(n_got - g0), 32'd0);
    rx.ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_clear", 32'(rx.valid), 32'h0);
    chk("bp_accepted", 32'(last_got), 32'h123456);
    gap(1000);
    chk("bp_latch", 32'(n_latch - l0c), 32'd1);

    // Short glitch after 5 good bits, then resync.
    g0 = n_got; e0 = n_err;
    send_bits(24'hF00000, 5, T0H, T1H, T0L, T1L);
    din = 1'b1; repeat (2) @(posedge clk); #1;
    gap(20);
    chk("glitch_err", 32'(n_err - e0), 32'd1);
    send_word(24'hFFFFFF);
    chk("glitch_ignored", 32'(n_got - g0), 32'd0);
    gap(1005);
    send_word(24'h00000F);
    gap(1000);
    chk("glitch_recover_n", 32'(n_got - g0), 32'd1);
    chk("glitch_recover_d", 32'(last_got), 32'h00000F);
    chk("glitch_err_once", 32'(n_err - e0), 32'd1);

    // Stuck-high line.
    g0 = n_got; e0 = n_err;
    din = 1'b1; v0 = cyc;
    repeat (60) @(posedge clk); #1;
    gap(20);
    chk("stuck_err", 32'(n_err - e0), 32'd1);
    chk("stuck_err_time", 32'(err_cyc - v0), 32'd42);
    send_word(24'h555555);
    chk("stuck_ignored", 32'(n_got - g0), 32'd0);
    gap(1005);
    send_word(24'hC3C3C3);
    gap(1000);
    chk("stuck_recover", 32'(last_got), 32'hC3C3C3);

    // Partial word at latch.
    g0 = n_got; e0 = n_err; l0c = n_latch;
    send_bits(24'hABCDEF, 10, T0H, T1H, T0L, T1L);
    gap(1005);
    chk("partial_latch", 32'(n_latch - l0c), 32'd1);
    chk("partial_err", 32'(n_err - e0), 32'd1);
    chk("partial_same_cycle", 32'(latch_cyc - err_cyc), 32'd0);
    chk("partial_no_valid", 32'(n_got - g0), 32'd0);
    send_word(24'h00FF00);
    gap(1000);
    chk("partial_next", 32'(last_got), 32'h00FF00);

    // Reset in the middle of a word with a word still held on the output.
    rx.ready = 1'b0;
    send_word(24'h5A5A5A);
    send_bits(24'hFFF000, 12, T0H, T1H, T0L, T1L);
    chk("mid_valid_before", 32'(rx.valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rx.valid), 32'h0);
    chk("mid_rst_data", 32'(rx.data_out), 32'h0);
    chk("mid_rst_pulses", 32'({rx.latch, rx.error, rx.overrun}), 32'h0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    rx.ready = 1'b1;
    g0 = n_got;
    send_word(24'h111111);
    gap(30);
    chk("mid_ignored", 32'(n_got - g0), 32'd0);
    gap(1005);
    send_word(24'h0F0F0F);
    gap(1000);
    chk("mid_recover_n", 32'(n_got - g0), 32'd1);
    chk("mid_recover_d", 32'(last_got), 32'h0F0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
